// File: rtl/imem_loader.sv
// imem_loader: assembles a little-endian byte stream into 32-bit words and writes them to instruction memory.
module imem_loader #(
  parameter int MEM_SIZE = 1024
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] word_count_i,
  input  logic        byte_valid_i,
  input  logic [7:0]  byte_i,
  output logic        byte_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic        cpu_hold_o
);
  localparam int IW = $clog2(MEM_SIZE);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RECV  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;
  logic [2:0]    r_state;
  logic [IW:0]   r_count;
  logic [IW-1:0] r_word_idx;
  logic [1:0]    r_byte_idx;
  logic [23:0]   r_word;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          w_last;
  assign w_last       = {1'b0, r_word_idx} == r_count - 1'b1;
  assign byte_ready_o = r_state == S_RECV;
  assign mem_we_o     = r_state == S_WRITE;
  assign busy_o       = r_state == S_RECV || r_state == S_WRITE;
  assign done_o       = r_state == S_DONE;
  assign error_o      = r_state == S_ERR;
  assign cpu_hold_o   = r_state != S_DONE;
  assign mem_addr_o   = r_addr;
  assign mem_wdata_o  = r_wdata;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_word_idx <= '0;
      r_byte_idx <= '0;
      r_word     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start_i) begin
            if (word_count_i == 32'd0) r_state <= S_DONE;
            else if (word_count_i > 32'(MEM_SIZE)) r_state <= S_ERR;
            else begin
              r_count    <= word_count_i[IW:0];
              r_word_idx <= '0;
              r_byte_idx <= '0;
              r_state    <= S_RECV;
            end
          end
        end
        S_RECV: begin
          if (byte_valid_i) begin
            // bytes shift in from the top so byte 0 ends up in the low lane
            r_word     <= {byte_i, r_word[23:8]};
            r_byte_idx <= r_byte_idx + 2'd1;
            if (r_byte_idx == 2'd3) begin
              r_addr  <= {{(32-IW){1'b0}}, r_word_idx};
              r_wdata <= {byte_i, r_word};
              r_state <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          if (w_last) r_state <= S_DONE;
          else begin
            r_word_idx <= r_word_idx + 1'b1;
            r_state    <= S_RECV;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule
